// File: rtl/tr_baser_link_ctrl.sv
// ---------------------------------------------------------------------------
// tr_baser_link_ctrl
//
// Link bring-up / recovery sequencer for the 10GBASE-R transceiver path.
// Holds the transceiver reset controller in reset, waits for TX/RX ready,
// waits for a stable RX block lock, then declares link_up. Loss of link
// beyond a tolerance window, or a timeout while bringing up, re-runs the
// reset sequence (a "retry").
//
// Optional feature macro: LINK_CTRL_STAT_EN
//   defined   -> clr_stat input and loss_cnt output exist; clr_stat clears
//                loss_cnt and retry_cnt.
//   undefined -> those ports are absent; retry_cnt is cleared only by rst_glbl.
//
// Ports
//   clk_glbl     in   system clock, sole clock of the block
//   rst_glbl     in   asynchronous active-high reset
//   force_rst    in   level; while high the FSM is held in RESET_HOLD
//   tx_ready     in   TX ready from transceiver reset controller
//   rx_ready     in   RX ready from transceiver reset controller
//   rx_blk_lock  in   RX block lock (PHY clock domain, synchronised here)
//   tr_rst       out  reset request to transceiver reset controller (reg)
//   link_up      out  link usable (reg)
//   state        out  FSM state: 0 RESET_HOLD, 1 WAIT_READY, 2 WAIT_LOCK,
//                     3 LINK_UP, 4 LOSS
//   retry_cnt    out  reset attempts after the first, saturating at 255
//   clr_stat     in   [LINK_CTRL_STAT_EN] clear loss_cnt and retry_cnt
//   loss_cnt     out  [LINK_CTRL_STAT_EN] LINK_UP->LOSS entries, sat 65535
// ---------------------------------------------------------------------------
module tr_baser_link_ctrl #(
  parameter int RST_CYCLES     = 64,
  parameter int READY_TIMEOUT  = 1000000,
  parameter int LOCK_TIMEOUT   = 1000000,
  parameter int LOCK_STABLE    = 1024,
  parameter int LOSS_TOLERANCE = 256,
  parameter int CNT_W          = 24
) (
  input  logic       clk_glbl,
  input  logic       rst_glbl,
  input  logic       force_rst,
  input  logic       tx_ready,
  input  logic       rx_ready,
  input  logic       rx_blk_lock,
  output logic       tr_rst,
  output logic       link_up,
  output logic [2:0] state,
  output logic [7:0] retry_cnt
`ifdef LINK_CTRL_STAT_EN
  ,
  input  logic        clr_stat,
  output logic [15:0] loss_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_WAIT_LOCK  = 3'd2,
    ST_LINK_UP    = 3'd3,
    ST_LOSS       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STBL_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST  = CNT_W'(LOSS_TOLERANCE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_r;
  state_t           state_n;
  state_t           fsm_next_s;
  logic             fsm_retry_s;
  logic             retry_inc_s;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] timer_n;
  logic [CNT_W-1:0] tot_r;     // total cycles spent in WAIT_LOCK
  logic [CNT_W-1:0] tot_n;
  logic             sync1_r;
  logic             sync2_r;
  logic             ok_s;
  logic             tr_rst_r;
  logic             link_up_r;
  logic [7:0]       retry_r;

  // Two-flop synchroniser for the PHY-domain block lock.
  always_ff @(posedge clk_glbl or posedge rst_glbl) begin
    if (rst_glbl) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= rx_blk_lock;
      sync2_r <= sync1_r;
    end
  end

  assign ok_s = tx_ready & rx_ready & sync2_r;

  // FSM transition table, before the force_rst override.
  always_comb begin
    fsm_next_s  = state_r;
    fsm_retry_s = 1'b0;
    case (state_r)
      ST_RESET_HOLD: begin
        if (timer_r == RST_LAST) begin
          fsm_next_s = ST_WAIT_READY;
        end else begin
          fsm_next_s = ST_RESET_HOLD;
        end
      end
      ST_WAIT_READY: begin
        if (tx_ready && rx_ready) begin
          fsm_next_s = ST_WAIT_LOCK;
        end else if (timer_r == READY_LAST) begin
          fsm_next_s  = ST_RESET_HOLD;
          fsm_retry_s = 1'b1;
        end else begin
          fsm_next_s = ST_WAIT_READY;
        end
      end
      ST_WAIT_LOCK: begin
        // Stability is checked first so it wins over a coincident timeout.
        if (ok_s && (timer_r == STBL_LAST)) begin
          fsm_next_s = ST_LINK_UP;
        end else if (tot_r == LOCK_LAST) begin
          fsm_next_s  = ST_RESET_HOLD;
          fsm_retry_s = 1'b1;
        end else begin
          fsm_next_s = ST_WAIT_LOCK;
        end
      end
      ST_LINK_UP: begin
        if (!ok_s) begin
          fsm_next_s = ST_LOSS;
        end else begin
          fsm_next_s = ST_LINK_UP;
        end
      end
      ST_LOSS: begin
        if (ok_s) begin
          fsm_next_s = ST_LINK_UP;
        end else if (timer_r == LOSS_LAST) begin
          fsm_next_s  = ST_RESET_HOLD;
          fsm_retry_s = 1'b1;
        end else begin
          fsm_next_s = ST_LOSS;
        end
      end
      default: begin
        // Unreachable encodings recover through a full reset sequence.
        fsm_next_s  = ST_RESET_HOLD;
        fsm_retry_s = 1'b1;
      end
    endcase
  end

  // Apply force_rst override and compute both timers.
  always_comb begin
    state_n     = fsm_next_s;
    retry_inc_s = fsm_retry_s;
    timer_n     = '0;
    tot_n       = '0;
    if (force_rst) begin
      state_n     = ST_RESET_HOLD;
      retry_inc_s = 1'b0;
    end else begin
      state_n     = fsm_next_s;
      retry_inc_s = fsm_retry_s;
    end

    // Shared timer: cleared on any state change or while forced; in
    // WAIT_LOCK it counts consecutive ok cycles only.
    if (force_rst || (state_n != state_r)) begin
      timer_n = '0;
    end else if ((state_r == ST_WAIT_LOCK) && !ok_s) begin
      timer_n = '0;
    end else if (timer_r == CNT_MAX) begin
      timer_n = timer_r;
    end else begin
      timer_n = timer_r + CNT_ONE;
    end

    // Total-time counter only runs while staying in WAIT_LOCK.
    if (force_rst || (state_n != state_r) || (state_r != ST_WAIT_LOCK)) begin
      tot_n = '0;
    end else if (tot_r == CNT_MAX) begin
      tot_n = tot_r;
    end else begin
      tot_n = tot_r + CNT_ONE;
    end
  end

  // State, timers and outputs decoded from next state (same-edge update).
  always_ff @(posedge clk_glbl or posedge rst_glbl) begin
    if (rst_glbl) begin
      state_r   <= ST_RESET_HOLD;
      timer_r   <= '0;
      tot_r     <= '0;
      tr_rst_r  <= 1'b1;
      link_up_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      timer_r   <= timer_n;
      tot_r     <= tot_n;
      tr_rst_r  <= (state_n == ST_RESET_HOLD);
      link_up_r <= (state_n == ST_LINK_UP);
    end
  end

`ifdef LINK_CTRL_STAT_EN
  logic        loss_ev_s;
  logic [15:0] loss_r;

  assign loss_ev_s = (state_r == ST_LINK_UP) && (state_n == ST_LOSS);

  // Retry counter; clear has priority over a coincident increment.
  always_ff @(posedge clk_glbl or posedge rst_glbl) begin
    if (rst_glbl) begin
      retry_r <= 8'd0;
    end else if (clr_stat) begin
      retry_r <= 8'd0;
    end else if (retry_inc_s && (retry_r != 8'hFF)) begin
      retry_r <= retry_r + 8'd1;
    end else begin
      retry_r <= retry_r;
    end
  end

  // Loss-event counter; clear has priority over a coincident increment.
  always_ff @(posedge clk_glbl or posedge rst_glbl) begin
    if (rst_glbl) begin
      loss_r <= 16'd0;
    end else if (clr_stat) begin
      loss_r <= 16'd0;
    end else if (loss_ev_s && (loss_r != 16'hFFFF)) begin
      loss_r <= loss_r + 16'd1;
    end else begin
      loss_r <= loss_r;
    end
  end

  assign loss_cnt = loss_r;
`else
  // Retry counter, cleared only by the global reset.
  always_ff @(posedge clk_glbl or posedge rst_glbl) begin
    if (rst_glbl) begin
      retry_r <= 8'd0;
    end else if (retry_inc_s && (retry_r != 8'hFF)) begin
      retry_r <= retry_r + 8'd1;
    end else begin
      retry_r <= retry_r;
    end
  end
`endif

  assign tr_rst    = tr_rst_r;
  assign link_up   = link_up_r;
  assign state     = state_r;
  assign retry_cnt = retry_r;

endmodule
